// File: rtl/spi_rx_buffer.sv
// Receive buffer behind an SPI master: captures each byte on the master's done strobe
// into a first-word fall-through FIFO and presents it over valid/ready with a sticky overflow flag.
module spi_rx_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             spi_done,
  input  logic [WIDTH-1:0] spi_data,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  input  logic             rx_ready,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             done_q;

  logic cap, push, pop, drop;

  // Rising-edge detect on the done strobe, so a held level counts once.
  assign cap  = en & spi_done & ~done_q;
  assign pop  = valid_q & rx_ready;
  assign push = cap & (~full_q | pop);
  assign drop = cap & ~push;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    full_d  = (level_d == LVL_W'(DEPTH));
    valid_d = (level_d != '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      done_q   <= spi_done;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and level define what is valid,
  // and rx_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= spi_data;
  end

  assign rx_valid = valid_q;
  assign rx_data  = valid_q ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Directed self-checking bench for spi_rx_buffer: capture, FIFO ordering, overflow,
// simultaneous push/pop when full, enable gating and asynchronous reset.
module tb_spi_rx_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic             spi_done;
  logic [WIDTH-1:0] spi_data;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             overflow;
  logic             ovf_clr;

  int n_checks = 0;
  int n_fails  = 0;

  spi_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .spi_done (spi_done),
    .spi_data (spi_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .level    (level),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle done pulse followed by an idle cycle so the edge detector rearms.
  task automatic send_byte(input logic [7:0] b);
    spi_done = 1'b1;
    spi_data = b;
    tick();
    spi_done = 1'b0;
    tick();
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_data"},  32'(rx_data),  32'(exp));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    rstn     = 1'b0;
    en       = 1'b1;
    spi_done = 1'b0;
    spi_data = '0;
    rx_ready = 1'b0;
    ovf_clr  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid",    32'(rx_valid), 32'd0);
    check("rst_data",     32'(rx_data),  32'd0);
    check("rst_level",    32'(level),    32'd0);
    check("rst_full",     32'(full),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rstn = 1'b1;

    // 1: first cycle after release, single pulse 0xA5, visible after one edge
    spi_done = 1'b1;
    spi_data = 8'hA5;
    tick();
    spi_done = 1'b0;
    check("t1_valid", 32'(rx_valid), 32'd1);
    check("t1_data",  32'(rx_data),  32'hA5);
    check("t1_level", 32'(level),    32'd1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("t1_pop_valid", 32'(rx_valid), 32'd0);
    check("t1_pop_level", 32'(level),    32'd0);

    // rx_ready while empty is ignored
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("empty_ready_level", 32'(level), 32'd0);

    // 2: spi_done held 4 cycles yields exactly one entry
    spi_done = 1'b1;
    spi_data = 8'h3C;
    repeat (4) tick();
    spi_done = 1'b0;
    tick();
    check("t2_level", 32'(level), 32'd1);
    pop_expect("t2", 8'h3C);
    check("t2_empty", 32'(level), 32'd0);

    // 3: 9 bytes with no reads, the ninth is dropped
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("t3_full8",  32'(full),     32'd1);
    check("t3_ovf8",   32'(overflow), 32'd0);
    send_byte(8'h09);
    check("t3_level",  32'(level),    32'd8);
    check("t3_full",   32'(full),     32'd1);
    check("t3_ovf",    32'(overflow), 32'd1);
    check("t3_stable", 32'(rx_data),  32'h01);
    for (int i = 1; i <= 8; i++) pop_expect($sformatf("t3_rd%0d", i), 8'(i));
    check("t3_drained_valid", 32'(rx_valid), 32'd0);
    check("t3_drained_level", 32'(level),    32'd0);

    // 5: clear, then drop and clear in the same cycle
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t5_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    check("t5_full", 32'(full), 32'd1);
    spi_done = 1'b1;
    spi_data = 8'h18;
    ovf_clr  = 1'b1;
    tick();
    spi_done = 1'b0;
    ovf_clr  = 1'b0;
    check("t5_set_wins", 32'(overflow), 32'd1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t5_clr2", 32'(overflow), 32'd0);

    // 4: full FIFO, capture 0x55 together with a pop
    check("t4_head", 32'(rx_data), 32'h10);
    spi_done = 1'b1;
    spi_data = 8'h55;
    rx_ready = 1'b1;
    tick();
    spi_done = 1'b0;
    rx_ready = 1'b0;
    check("t4_level", 32'(level),    32'd8);
    check("t4_full",  32'(full),     32'd1);
    check("t4_ovf",   32'(overflow), 32'd0);
    tick();
    for (int i = 1; i < 8; i++) pop_expect($sformatf("t4_rd%0d", i), 8'h10 + 8'(i));
    pop_expect("t4_last", 8'h55);
    check("t4_empty", 32'(level), 32'd0);

    // 6: asynchronous reset mid-read, then en=0 blocks capture
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    check("t6_level3", 32'(level), 32'd3);
    rx_ready = 1'b1;
    tick();
    #2;
    rstn = 1'b0;
    #1;
    rx_ready = 1'b0;
    check("t6_rst_valid", 32'(rx_valid), 32'd0);
    check("t6_rst_data",  32'(rx_data),  32'd0);
    check("t6_rst_level", 32'(level),    32'd0);
    check("t6_rst_full",  32'(full),     32'd0);
    #1;
    rstn = 1'b1;
    en   = 1'b0;
    send_byte(8'h77);
    check("t6_en0_level", 32'(level),    32'd0);
    check("t6_en0_valid", 32'(rx_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
